// File: rtl/job_seq_if.sv
// job_seq_if: control, status and stream-handshake bundle for job_seq.
interface job_seq_if #(
   parameter int MAT_W = 7,
   parameter int CNT_W = 20
);
   logic             start, abort, src_v, s_fin;
   logic             dst_valid, dst_ready, dst_last;
   logic [MAT_W-1:0] item_num, mat_a;
   logic [CNT_W-1:0] beat_num, beat_cnt;
   logic             matw, run, busy, done, err;
   logic [2:0]       state;
   modport master (
      output start, abort, item_num, beat_num, src_v, s_fin, dst_valid, dst_ready, dst_last,
      input  matw, run, mat_a, beat_cnt, busy, done, err, state
   );
   modport slave (
      input  start, abort, item_num, beat_num, src_v, s_fin, dst_valid, dst_ready, dst_last,
      output matw, run, mat_a, beat_cnt, busy, done, err, state
   );
endinterface

// File: rtl/job_seq.sv
// job_seq: job sequencer (item-memory write, run, drain, done/err); optional watchdog under JOB_SEQ_TIMEOUT_EN.
module job_seq #(
   parameter int MAT_W  = 7,
   parameter int CNT_W  = 20,
   parameter int TO_CYC = 65535
) (
   input logic      clk,
   input logic      rst,
   job_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MATW  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [MAT_W-1:0] mat_a_q, mat_a_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_inc;
   logic             go, hs, entry, wd_hit;

`ifdef JOB_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TO_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   assign wd_hit = (state_q == MATW || state_q == RUN || state_q == DRAIN) && wd_q == WD_W'(TO_CYC - 1);
   // Restart on any sign of progress so only a genuinely stalled job times out
   always_comb begin
      wd_d = (state_d != state_q || bus.src_v || (bus.dst_valid && bus.dst_ready)) ? '0 :
             (wd_q == '1) ? wd_q : wd_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mat_a_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mat_a_q    <= mat_a_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // The s_fin decision includes a beat accepted in the same cycle
   always_comb begin
      go       = bus.start && !bus.abort;
      hs       = bus.dst_valid && bus.dst_ready && bus.dst_last;
      beat_inc = (bus.src_v && beat_cnt_q != '1) ? beat_cnt_q + 1'b1 : beat_cnt_q;
      state_d  = state_q;
      case (state_q)
         IDLE:    state_d = go ? MATW : IDLE;
         MATW:    state_d = (mat_a_q == bus.item_num) ? RUN : MATW;
         RUN:     state_d = bus.s_fin ? ((beat_inc == bus.beat_num) ? DRAIN : ERR) : RUN;
         DRAIN:   state_d = hs ? DONE : DRAIN;
         DONE:    state_d = IDLE;
         ERR:     state_d = go ? MATW : ERR;
         default: state_d = IDLE;
      endcase
      state_d    = bus.abort ? IDLE : wd_hit ? ERR : state_d;
      entry      = state_d == MATW && state_q != MATW;
      mat_a_d    = entry ? '0 : (state_q == MATW && mat_a_q != bus.item_num) ? mat_a_q + 1'b1 : mat_a_q;
      beat_cnt_d = entry ? '0 : (state_q == RUN) ? beat_inc : beat_cnt_q;
   end

   always_comb begin
      bus.matw     = state_q == MATW;
      bus.run      = state_q == RUN || state_q == DRAIN;
      bus.busy     = state_q == MATW || state_q == RUN || state_q == DRAIN;
      bus.done     = state_q == DONE;
      bus.err      = state_q == ERR;
      bus.mat_a    = mat_a_q;
      bus.beat_cnt = beat_cnt_q;
      bus.state    = state_q;
   end
endmodule

// File: tb/tb_job_seq.sv
// tb_job_seq: directed and randomized job checks against a job-level outcome model.
module tb_job_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total = 0;
   int   matw_cnt, done_cnt, seq_bad;

   always #5 clk = ~clk;

   job_seq_if #(.MAT_W(7), .CNT_W(20)) j ();
   job_seq #(.MAT_W(7), .CNT_W(20), .TO_CYC(65535)) dut (.clk(clk), .rst(rst), .bus(j));

`ifdef JOB_SEQ_TIMEOUT_EN
   job_seq_if #(.MAT_W(7), .CNT_W(20)) j2 ();
   job_seq #(.MAT_W(7), .CNT_W(20), .TO_CYC(16)) dut2 (.clk(clk), .rst(rst), .bus(j2));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one cycle and sample just after the edge; accumulate job statistics
   task automatic tick();
      @(posedge clk);
      #1;
      if (j.matw) begin
         if (j.mat_a !== 7'(matw_cnt)) seq_bad++;
         matw_cnt++;
      end
      if (j.done) done_cnt++;
   endtask

   // Job-level model: item+1 write cycles, success iff accepted beats equal beat_num
   task automatic run_job(input int item, input int bn, input int ns, input int stall);
      int  k;
      bit  ok, fused;
      ok = (ns == bn);
      matw_cnt = 0; done_cnt = 0; seq_bad = 0;
      j.item_num = 7'(item); j.beat_num = 20'(bn); j.start = 1'b1;
      tick();
      j.start = 1'b0;
      chk("busy_after_start", j.busy, 1);
      k = 0;
      while (j.state == 3'd1 && k < 300) begin tick(); k++; end
      chk("matw_len", matw_cnt, item + 1);
      chk("mat_a_seq", seq_bad, 0);
      chk("enter_run", j.state, 2);
      fused = 1'b0;
      for (int i = 0; i < ns; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         j.src_v = 1'b1;
         if (i == ns - 1 && $urandom_range(0, 1) == 1) begin j.s_fin = 1'b1; fused = 1'b1; end
         tick();
         j.src_v = 1'b0; j.s_fin = 1'b0;
      end
      if (!fused) begin j.s_fin = 1'b1; tick(); j.s_fin = 1'b0; end
      chk("beat_cnt", j.beat_cnt, ns);
      chk("after_fin_state", j.state, ok ? 3 : 5);
      if (ok) begin
         k = 0;
         j.dst_valid = 1'b1; j.dst_last = 1'b1; j.dst_ready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            j.start = (i == 0);
            tick();
            if (j.state == 3'd3 && j.run) k++;
         end
         j.start = 1'b0;
         chk("drain_hold", k, stall);
         j.dst_ready = 1'b1;
         tick();
         j.dst_valid = 1'b0; j.dst_last = 1'b0; j.dst_ready = 1'b0;
         chk("done_state", j.state, 4);
         chk("done_run_low", j.run, 0);
         tick();
         chk("back_idle", j.state, 0);
         chk("done_pulses", done_cnt, 1);
      end else begin
         chk("err_flag", j.err, 1);
         chk("err_run_low", j.run, 0);
         chk("err_no_done", done_cnt, 0);
      end
   endtask

   initial begin
      j.start = 0; j.abort = 0; j.src_v = 0; j.s_fin = 0;
      j.dst_valid = 0; j.dst_ready = 0; j.dst_last = 0;
      j.item_num = '0; j.beat_num = '0;
`ifdef JOB_SEQ_TIMEOUT_EN
      j2.start = 0; j2.abort = 0; j2.src_v = 0; j2.s_fin = 0;
      j2.dst_valid = 0; j2.dst_ready = 0; j2.dst_last = 0;
      j2.item_num = '0; j2.beat_num = 20'd1;
`endif
      matw_cnt = 0; done_cnt = 0; seq_bad = 0;
      repeat (2) tick();
      chk("rst_state", j.state, 0);
      chk("rst_busy", j.busy, 0);
      chk("rst_matw", j.matw, 0);
      chk("rst_run", j.run, 0);
      chk("rst_done", j.done, 0);
      chk("rst_err", j.err, 0);
      chk("rst_mat_a", j.mat_a, 0);
      chk("rst_beat_cnt", j.beat_cnt, 0);
      rst = 1'b0;
      tick();

      run_job(99, 30, 30, 0);
      run_job(99, 30, 30, 5);
      run_job(0, 3, 3, 0);

      run_job(10, 30, 29, 0);
      j.start = 1'b1;
      tick();
      j.start = 1'b0;
      chk("restart_from_err", j.state, 1);
      chk("restart_err_clr", j.err, 0);
      j.abort = 1'b1;
      tick();
      j.abort = 1'b0;
      chk("abort_matw", j.state, 0);

      j.start = 1'b1; j.abort = 1'b1;
      tick();
      j.start = 1'b0; j.abort = 1'b0;
      chk("abort_beats_start", j.state, 0);

      j.item_num = 7'd3; j.beat_num = 20'd30; j.start = 1'b1;
      tick();
      j.start = 1'b0;
      repeat (4) tick();
      chk("abort_job_run", j.state, 2);
      done_cnt = 0;
      j.src_v = 1'b1;
      repeat (10) tick();
      j.src_v = 1'b0;
      chk("abort_job_beats", j.beat_cnt, 10);
      j.abort = 1'b1;
      tick();
      j.abort = 1'b0;
      chk("abort_run_idle", j.state, 0);
      chk("abort_run_low", j.run, 0);
      repeat (3) tick();
      chk("abort_no_done", done_cnt, 0);

      j.item_num = 7'd99; j.start = 1'b1;
      tick();
      j.start = 1'b0;
      for (int k = 0; k < 200 && j.mat_a != 7'd50; k++) tick();
      chk("mid_matw_addr", j.mat_a, 50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_state", j.state, 0);
      chk("mid_rst_matw", j.matw, 0);
      chk("mid_rst_busy", j.busy, 0);
      chk("mid_rst_mat_a", j.mat_a, 0);
      chk("mid_rst_beat", j.beat_cnt, 0);

      for (int r = 0; r < 8; r++) begin
         int item, bn, ns;
         item = $urandom_range(0, 20);
         bn   = $urandom_range(1, 12);
         ns   = ($urandom_range(0, 1) == 1) ? bn : $urandom_range(0, 12);
         run_job(item, bn, ns, $urandom_range(0, 3));
      end

`ifdef JOB_SEQ_TIMEOUT_EN
      j2.start = 1'b1;
      tick();
      j2.start = 1'b0;
      tick();
      chk("wd_run", j2.state, 2);
      repeat (15) tick();
      chk("wd_still_run", j2.state, 2);
      tick();
      chk("wd_err", j2.state, 5);
      chk("wd_err_flag", j2.err, 1);
`else
      j.item_num = 7'd0; j.beat_num = 20'd1; j.start = 1'b1;
      tick();
      j.start = 1'b0;
      tick();
      chk("nowd_run", j.state, 2);
      repeat (40) tick();
      chk("nowd_still_run", j.state, 2);
      j.abort = 1'b1;
      tick();
      j.abort = 1'b0;
      chk("nowd_abort", j.state, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
